// File: rtl/drift_pkg.sv
// rtl/drift_pkg.sv - shared types and constants for the drift event sequencer
package drift_pkg;

    localparam int N_TUBES         = 32;
    localparam int TIME_W          = 8;
    localparam int N_GROUPS        = 4;
    localparam int TUBES_PER_GROUP = 8;
    localparam int HDR_CNT_W       = 13;

    localparam int IDX_W = $clog2(N_TUBES);
    localparam int GRP_W = $clog2(N_GROUPS);
    localparam int SUB_W = $clog2(TUBES_PER_GROUP);

    localparam logic [2:0] HDR_TAG = 3'b110;
    localparam logic [2:0] HIT_TAG = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_HDR,
        ST_HIT
    } state_e;

    typedef enum logic [1:0] {
        G3A = 2'd0,
        G3B = 2'd1,
        G4A = 2'd2,
        G4B = 2'd3
    } group_e;

endpackage

// File: rtl/drift_word_fmt.sv
// rtl/drift_word_fmt.sv - combinational packing of header and hit words
module drift_word_fmt
    import drift_pkg::*;
#(
    parameter int EVT_ID_W = 13
) (
    input  state_e              state,
    input  logic [IDX_W-1:0]    idx,
    input  logic [TIME_W-1:0]   tube_time,
    input  logic [EVT_ID_W-1:0] evt_count,
    output logic [15:0]         word
);

    // The header carries exactly 13 counter bits: narrower counters are
    // zero-extended, wider ones keep only their low bits.
    localparam int EXT_W = (EVT_ID_W > HDR_CNT_W) ? EVT_ID_W : HDR_CNT_W;

    logic [EXT_W-1:0] cnt_ext;
    group_e           grp;
    logic [SUB_W-1:0] sub;

    assign cnt_ext = EXT_W'(evt_count);
    assign grp     = group_e'(idx[IDX_W-1 -: GRP_W]);
    assign sub     = idx[SUB_W-1:0];

    always_comb begin
        word = '0;
        case (state)
            ST_HDR:  word = {HDR_TAG, cnt_ext[HDR_CNT_W-1:0]};
            ST_HIT:  word = {HIT_TAG, grp, sub, tube_time};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/drift_event_sequencer.sv
// rtl/drift_event_sequencer.sv - unpacks 256-bit drift events into 16-bit output FIFO words
// Optional zero suppression of NO_HIT tubes is enabled by defining ZERO_SUPPRESS_EN.
module drift_event_sequencer
    import drift_pkg::*;
#(
    parameter int         FIFO_RD_LAT = 1,
    parameter int         EVT_ID_W    = 13,
    parameter logic [7:0] NO_HIT      = 8'hFF
) (
    input  logic                clk100,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                evt_empty,
    output logic                evt_rd_en,
    input  logic [255:0]        evt_dout,
    input  logic                out_full,
    output logic                out_wr_en,
    output logic [15:0]         out_din,
    output logic                busy,
    output logic [EVT_ID_W-1:0] evt_count
);

`ifdef ZERO_SUPPRESS_EN
    localparam bit ZS_ON = 1'b1;
`else
    localparam bit ZS_ON = 1'b0;
`endif

    state_e              state;
    logic [IDX_W-1:0]    idx;
    logic [1:0]          wait_cnt;
    logic [255:0]        evt_reg;
    logic [TIME_W-1:0]   tubes [N_TUBES];
    logic [TIME_W-1:0]   cur_time;
    logic                skip;

    // Tube 0 sits in the most significant byte of the event word.
    always_comb begin
        for (int k = 0; k < N_TUBES; k++) begin
            tubes[k] = evt_reg[N_TUBES*TIME_W-1 - TIME_W*k -: TIME_W];
        end
    end

    assign cur_time  = tubes[idx];
    assign skip      = ZS_ON && (state == ST_HIT) && (cur_time == NO_HIT);
    assign out_wr_en = !out_full && ((state == ST_HDR) || ((state == ST_HIT) && !skip));
    assign busy      = (state != ST_IDLE);

    drift_word_fmt #(
        .EVT_ID_W (EVT_ID_W)
    ) u_word_fmt (
        .state     (state),
        .idx       (idx),
        .tube_time (cur_time),
        .evt_count (evt_count),
        .word      (out_din)
    );

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            evt_rd_en <= 1'b0;
            idx       <= '0;
            wait_cnt  <= '0;
            evt_reg   <= '1;
            evt_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && !evt_empty) begin
                        evt_rd_en <= 1'b1;
                        state     <= ST_RD;
                    end
                end
                ST_RD: begin
                    evt_rd_en <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == 2'(FIFO_RD_LAT - 1)) begin
                        evt_reg <= evt_dout;
                        state   <= ST_HDR;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ST_HDR: begin
                    if (out_wr_en) begin
                        idx   <= '0;
                        state <= ST_HIT;
                    end
                end
                ST_HIT: begin
                    // A suppressed tube advances exactly like a written one.
                    if (out_wr_en || skip) begin
                        idx <= idx + 1'b1;
                        if (idx == IDX_W'(N_TUBES - 1)) begin
                            evt_count <= evt_count + 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    evt_rd_en <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drift_event_sequencer.sv
// tb/tb_drift_event_sequencer.sv - directed self-checking bench for drift_event_sequencer
module tb_drift_event_sequencer;

    logic         clk100 = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         evt_empty;
    logic         evt_rd_en;
    logic [255:0] evt_dout;
    logic         out_full;
    logic         out_wr_en;
    logic [15:0]  out_din;
    logic         busy;
    logic [12:0]  evt_count;

    drift_event_sequencer #(
        .FIFO_RD_LAT (1),
        .EVT_ID_W    (13),
        .NO_HIT      (8'hFF)
    ) dut (
        .clk100    (clk100),
        .rst_n     (rst_n),
        .enable    (enable),
        .evt_empty (evt_empty),
        .evt_rd_en (evt_rd_en),
        .evt_dout  (evt_dout),
        .out_full  (out_full),
        .out_wr_en (out_wr_en),
        .out_din   (out_din),
        .busy      (busy),
        .evt_count (evt_count)
    );

    always #5 clk100 = ~clk100;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int pushed = 0;
    int full_viol = 0;
    int full_cyc = 0;
    int full_hold = 0;
    logic [15:0] got [$];
    int wr_cyc [$];
    int rd_cyc [$];

    assign evt_empty = (pushed <= rd_cnt);

    always @(negedge clk100) begin
        cyc = cyc + 1;
        if (rst_n && out_wr_en) begin
            got.push_back(out_din);
            wr_cyc.push_back(cyc);
            if (out_full) full_viol = full_viol + 1;
        end
        if (rst_n && evt_rd_en) begin
            rd_cnt = rd_cnt + 1;
            rd_cyc.push_back(cyc);
        end
        if (out_full && busy) begin
            full_cyc = full_cyc + 1;
            if (out_din == 16'hAA0A && !out_wr_en) full_hold = full_hold + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] word_at(input int i);
        if (i >= 0 && i < got.size()) return got[i];
        return 16'hDEAD;
    endfunction

    function automatic logic [255:0] pattern_k();
        logic [255:0] w;
        for (int k = 0; k < 32; k++) w[255-8*k -: 8] = 8'(k);
        return w;
    endfunction

    function automatic logic [15:0] exp_hit(input int k, input logic [7:0] t);
        logic [4:0] kk;
        kk = 5'(k);
        return {3'b101, kk, t};
    endfunction

    // Starts one event from IDLE and returns cycles from the IDLE cycle back to IDLE.
    task automatic run_event(input logic [255:0] w, output int ncyc, output int start_cyc);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        evt_dout = w;
        @(posedge clk100); #1;
        start_cyc = cyc;
        pushed = rd_cnt + 1;
        while (n < 300) begin
            @(negedge clk100);
            n = n + 1;
            if (busy) seen = 1;
            else if (seen) break;
        end
        if (n >= 300) check("event_timeout", 32'(n), 32'd0);
        ncyc = n - 1;
    endtask

    typedef struct {
        int          idx;
        logic [7:0]  t;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [6];
    int   exp_count;

    initial begin
        int base;
        int rb;
        int ncyc;
        int st;
        int n;
        int hits;
        logic [255:0] w;

        vecs[0] = '{idx: 0,  t: 8'h00, exp: 16'hA000};
        vecs[1] = '{idx: 5,  t: 8'hC3, exp: 16'hA5C3};
        vecs[2] = '{idx: 12, t: 8'h7E, exp: 16'hAC7E};
        vecs[3] = '{idx: 19, t: 8'h00, exp: 16'hB300};
        vecs[4] = '{idx: 26, t: 8'h80, exp: 16'hBA80};
        vecs[5] = '{idx: 31, t: 8'h1F, exp: 16'hBF1F};

        rst_n = 1'b0;
        enable = 1'b1;
        out_full = 1'b0;
        evt_dout = '0;
        repeat (3) @(posedge clk100);
        #1;
        check("rst_rd_en", 32'(evt_rd_en), 32'd0);
        check("rst_wr_en", 32'(out_wr_en), 32'd0);
        check("rst_din", 32'(out_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(evt_count), 32'd0);
        rst_n = 1'b1;
        exp_count = 0;
        @(posedge clk100); #1;

        // single event, tube k time = k
        base = got.size();
        run_event(pattern_k(), ncyc, st);
        check("ev1_words", 32'(got.size() - base), 32'd33);
        check("ev1_hdr", 32'(word_at(base)), 32'hC000);
        check("ev1_w1", 32'(word_at(base + 2)), 32'hA101);
        check("ev1_w31", 32'(word_at(base + 32)), 32'hBF1F);
        for (int k = 0; k < 32; k++)
            check("ev1_hit", 32'(word_at(base + 1 + k)), 32'(exp_hit(k, 8'(k))));
        check("ev1_cycles", 32'(ncyc), 32'd36);
        if (wr_cyc.size() > base) check("ev1_hdr_lat", 32'(wr_cyc[base] - st), 32'd4);
        else check("ev1_hdr_lat_missing", 32'(wr_cyc.size()), 32'(base + 1));
        exp_count = exp_count + 1;
        check("ev1_count", 32'(evt_count), 32'(exp_count));

        // table of single-tube overrides
        for (int v = 0; v < 6; v++) begin
            w = pattern_k();
            w[255-8*vecs[v].idx -: 8] = vecs[v].t;
            base = got.size();
            run_event(w, ncyc, st);
            check("vec_words", 32'(got.size() - base), 32'd33);
            check("vec_hdr", 32'(word_at(base)), 32'({3'b110, 13'(exp_count)}));
            check("vec_hit", 32'(word_at(base + 1 + vecs[v].idx)), 32'(vecs[v].exp));
            exp_count = exp_count + 1;
            check("vec_count", 32'(evt_count), 32'(exp_count));
        end

        // back-pressure for 5 cycles at idx 10
        base = got.size();
        fork
            run_event(pattern_k(), ncyc, st);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk100); #1;
                    if (out_din == 16'hAA0A) begin
                        out_full = 1'b1;
                        repeat (5) @(posedge clk100);
                        #1;
                        out_full = 1'b0;
                        break;
                    end
                end
            end
        join
        hits = 0;
        for (int i = base; i < got.size(); i++) if (got[i] == 16'hAA0A) hits = hits + 1;
        check("stall_words", 32'(got.size() - base), 32'd33);
        check("stall_aa0a_once", 32'(hits), 32'd1);
        check("stall_w10", 32'(word_at(base + 11)), 32'hAA0A);
        check("stall_w11", 32'(word_at(base + 12)), 32'hAB0B);
        check("stall_full_cycles", 32'(full_cyc), 32'd5);
        check("stall_din_held", 32'(full_hold), 32'd5);
        check("stall_no_wr_when_full", 32'(full_viol), 32'd0);
        check("stall_cycles", 32'(ncyc), 32'd41);

        // two queued events after a fresh reset
        @(posedge clk100); #1;
        rst_n = 1'b0;
        @(posedge clk100); #1;
        rst_n = 1'b1;
        exp_count = 0;
        base = got.size();
        rb = rd_cyc.size();
        evt_dout = pattern_k();
        pushed = rd_cnt + 2;
        n = 0;
        while (n < 300 && !(evt_count == 13'd2 && !busy)) begin
            @(negedge clk100);
            n = n + 1;
        end
        check("two_timeout", 32'(n < 300), 32'd1);
        check("two_words", 32'(got.size() - base), 32'd66);
        check("two_hdr0", 32'(word_at(base)), 32'hC000);
        check("two_hdr1", 32'(word_at(base + 33)), 32'hC001);
        if (rd_cyc.size() >= rb + 2 && wr_cyc.size() >= base + 33)
            check("two_gap", 32'(rd_cyc[rb+1] - wr_cyc[base+32]), 32'd2);
        else
            check("two_gap_missing", 32'(rd_cyc.size()), 32'(rb + 2));
        exp_count = 2;

        // enable low blocks new events; dropping it mid-event does not abort
        @(posedge clk100); #1;
        enable = 1'b0;
        rb = rd_cnt;
        pushed = rd_cnt + 1;
        repeat (20) @(negedge clk100);
        check("en0_no_rd", 32'(rd_cnt - rb), 32'd0);
        check("en0_idle", 32'(busy), 32'd0);
        base = got.size();
        @(posedge clk100); #1;
        enable = 1'b1;
        repeat (5) @(posedge clk100);
        #1;
        enable = 1'b0;
        n = 0;
        while (n < 300 && busy) begin
            @(negedge clk100);
            n = n + 1;
        end
        check("endrop_timeout", 32'(n < 300), 32'd1);
        check("endrop_words", 32'(got.size() - base), 32'd33);
        exp_count = exp_count + 1;
        check("endrop_count", 32'(evt_count), 32'(exp_count));
        rb = rd_cnt;
        pushed = rd_cnt + 1;
        repeat (20) @(negedge clk100);
        check("endrop_no_next", 32'(rd_cnt - rb), 32'd0);
        pushed = rd_cnt;
        enable = 1'b1;

        // asynchronous reset at idx 17
        evt_dout = pattern_k();
        @(posedge clk100); #1;
        pushed = rd_cnt + 1;
        n = 0;
        while (n < 200 && out_din != 16'hB111) begin
            @(posedge clk100); #1;
            n = n + 1;
        end
        check("mid_reached_17", 32'(n < 200), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_din", 32'(out_din), 32'd0);
        check("mid_rst_wr", 32'(out_wr_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(evt_count), 32'd0);
        check("mid_rst_rd", 32'(evt_rd_en), 32'd0);
        repeat (2) @(posedge clk100);
        #1;
        rst_n = 1'b1;
        exp_count = 0;
        base = got.size();
        run_event(pattern_k(), ncyc, st);
        check("post_rst_hdr", 32'(word_at(base)), 32'hC000);
        check("post_rst_words", 32'(got.size() - base), 32'd33);
        exp_count = 1;

        w = '1;
        w[255-8*3 -: 8] = 8'h12;
        w[255-8*31 -: 8] = 8'h34;
        base = got.size();
        run_event(w, ncyc, st);
`ifdef ZERO_SUPPRESS_EN
        check("zs_words", 32'(got.size() - base), 32'd3);
        check("zs_hdr", 32'(word_at(base)), 32'hC001);
        check("zs_t3", 32'(word_at(base + 1)), 32'hA312);
        check("zs_t31", 32'(word_at(base + 2)), 32'hBF34);
        check("zs_cycles", 32'(ncyc), 32'd36);
`else
        check("nohit_words", 32'(got.size() - base), 32'd33);
        check("nohit_hdr", 32'(word_at(base)), 32'hC001);
        check("nohit_t0", 32'(word_at(base + 1)), 32'hA0FF);
        check("nohit_t3", 32'(word_at(base + 4)), 32'hA312);
        check("nohit_t31", 32'(word_at(base + 32)), 32'hBF34);
`endif
        exp_count = exp_count + 1;
        check("last_count", 32'(evt_count), 32'(exp_count));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
